addi_host_seq: RTL and testbench
================================

# addi_host_seq

Host-side sequencer for the 4-bit ADDI coprocessor. It holds a 4×4 register file, issues `opcode = 1` with an immediate, and answers the coprocessor's operand request by driving a register value on the shared 4-bit bus. It then collects the sum and carry when `done` rises and writes the result back to a destination register. It is the initiator/responder counterpart of the coprocessor and sits between the user-facing control logic and the coprocessor pins.

## Interface
- `TIMEOUT`, default 15: cycles allowed from ISSUE entry to completion before abort.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request one ADDI; accepted only in IDLE.
- `imm` in 4: immediate, latched at accept.
- `src` in 2: source register index, latched at accept.
- `dst` in 2: destination register index, latched at accept.
- `ld_en`, `ld_addr[1:0]`, `ld_data[3:0]` in: register-file load port.
- `rd_addr` in 2: register-file read index.
- `rd_data` out 4: `regs[rd_addr]`, combinational.
- `busy` out 1: high in any state other than IDLE.
- `res_valid` out 1: one-cycle pulse on successful writeback.
- `err` out 1: one-cycle pulse on timeout abort.
- `cflag` out 1: carry of the last successful ADDI.
- `cp_opcode` out 4, `cp_imm` out 4: to coprocessor opcode and immediate inputs.
- `cp_bus_req` in 4: coprocessor request code; `0011` = operand request, `0001` = operand transfer.
- `cp_bus_out` out 4, `cp_bus_oe` out 1: host drive of the shared bus.
- `cp_bus_in` in 4: shared bus as seen by host.
- `cp_oe_n` out 1: low requests the coprocessor to drive its result.
- `cp_done` in 1, `cp_carry` in 1: coprocessor completion and carry.

## Operation
- Registers: `regs[0..3]`, `op_val`, `imm_q`, `dst_q`, `done_q`, `tcnt[3:0]`, `cflag`. States: IDLE, ISSUE, WAIT.
- Reset: all registers 0. Outputs are 0 except `cp_oe_n` = 1. `done_q` = 0.
- IDLE: `cp_opcode` = 0, `cp_bus_oe` = 0, `cp_oe_n` = 1. On `start`: `op_val <= regs[src]`, latch `imm` and `dst`, `tcnt <= 0`, go to ISSUE.
- ISSUE: `cp_opcode` = 1, `cp_imm` = `imm_q`, `cp_bus_out` = `op_val`, `cp_bus_oe` = 1, `cp_oe_n` = 0. When sampled `cp_bus_req == 0001`, go to WAIT. `cp_bus_oe` is held high through that edge, because the coprocessor samples on the same edge.
- WAIT: `cp_opcode` = 1, `cp_bus_oe` = 0, `cp_oe_n` = 0.
  - Completion requires `cp_done == 1 && done_q == 0` (a rising edge).
  - On completion: `regs[dst_q] <= cp_bus_in`, `cflag <= cp_carry`, `res_valid` pulses, go to IDLE.
- `cp_bus_req == 0011` is informational. No host action is taken on it.
- `done_q <= cp_done` every cycle in all states. A stale `done` held high from a previous op never completes a new op.
- Timeout: `tcnt` increments each cycle in ISSUE and WAIT. When `tcnt == TIMEOUT` without completion: `err` pulses, no register write, `cflag` unchanged, go to IDLE.
- `start` while busy is ignored and not queued.
- Load port: `ld_en` writes `regs[ld_addr] <= ld_data` in any state.
  - If a load and a completion writeback hit the same register on the same edge, the writeback wins.
  - A load to `src` after accept does not affect the in-flight `op_val`.
- Arithmetic happens entirely in the coprocessor. The host stores the 4-bit sum and carry unmodified.
- `rst` asserted mid-op: next edge forces IDLE and clears all state, including `regs`. The bus is released and `cp_opcode` = 0 from that edge.

## Timing
- Accept edge E0 → ISSUE.
- With a compliant coprocessor:
  - `cp_bus_req` = 0011 after E1 and 0001 after E2.
  - Host sees 0001 at E3 → WAIT; coprocessor samples the operand at E3.
  - `cp_done` rises after E5.
  - Host completes at E6; `res_valid` is high in the cycle after E6.
- Total latency: 6 cycles accept→`res_valid`. `busy` is high for 6 cycles.
- Back-to-back: the next `start` is accepted in the cycle `res_valid` is high (state is already IDLE).
- Timeout abort: `err` is high in the cycle after edge E0+`TIMEOUT`+1.
- `rd_data` reflects a load or writeback the cycle after the writing edge.

## Test plan
- Load r1 = 5; start `imm` = 3, `src` = 1, `dst` = 2 with a coprocessor model → `res_valid` 6 cycles after accept, r2 = 8, `cflag` = 0.
- Load r0 = 9; `imm` = 7, `src` = 0, `dst` = 0 → r0 = 0, `cflag` = 1; the coprocessor sampled `cp_bus_in` = 9 at E3.
- Model never asserts `cp_done`, `TIMEOUT` = 15 → `err` pulse after E16, r-file unchanged, `busy` = 0 afterwards.
- `cp_done` held at 1 for the whole op → no `res_valid`, `err` on timeout. Then a normal op succeeds.
- `rst` asserted at E3 of an op → next cycle `busy` = 0, `cp_opcode` = 0, `cp_bus_oe` = 0, all regs 0.
- Completion to r3 with a simultaneous `ld_en` to r3 (`ld_data` = F) → r3 = sum. A `start` pulse during `busy` → ignored, exactly one `res_valid`.

Source files
------------

// File: rtl/addi_host_seq.sv
// Host-side sequencer for the 4-bit ADDI coprocessor: owns a 4x4 register file,
// issues ADDI with an immediate, serves the operand on the shared bus and writes back the result.
module addi_host_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] imm_i,
    input  logic [1:0] src_i,
    input  logic [1:0] dst_i,
    input  logic       ld_en_i,
    input  logic [1:0] ld_addr_i,
    input  logic [3:0] ld_data_i,
    input  logic [1:0] rd_addr_i,
    output logic [3:0] rd_data_o,
    output logic       busy_o,
    output logic       res_valid_o,
    output logic       err_o,
    output logic       cflag_o,
    output logic [3:0] cp_opcode_o,
    output logic [3:0] cp_imm_o,
    input  logic [3:0] cp_bus_req_i,
    output logic [3:0] cp_bus_out_o,
    output logic       cp_bus_oe_o,
    input  logic [3:0] cp_bus_in_i,
    output logic       cp_oe_n_o,
    input  logic       cp_done_i,
    input  logic       cp_carry_i
);

    // state   | meaning
    // S_IDLE  | bus released, waiting for start
    // S_ISSUE | opcode=1, host drives operand until the coprocessor signals transfer
    // S_WAIT  | bus released, waiting for a rising cp_done
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [3:0] REQ_XFER = 4'b0001;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] TMO      = 4'(TIMEOUT);

    state_t     state_q;
    logic [3:0] regs_q [4];
    logic [3:0] op_val_q;
    logic [3:0] imm_q;
    logic [1:0] dst_q;
    logic       done_q;
    logic [3:0] tcnt_q;
    logic       cflag_q;
    logic       res_valid_q;
    logic       err_q;
    logic       busy_q;
    logic [3:0] opcode_q;
    logic       bus_oe_q;
    logic       oe_n_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            op_val_q    <= '0;
            imm_q       <= '0;
            dst_q       <= '0;
            done_q      <= 1'b0;
            tcnt_q      <= '0;
            cflag_q     <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            opcode_q    <= '0;
            bus_oe_q    <= 1'b0;
            oe_n_q      <= 1'b1;
        end else begin
            done_q      <= cp_done_i;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            if (ld_en_i) regs_q[ld_addr_i] <= ld_data_i;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_val_q <= regs_q[src_i];
                        imm_q    <= imm_i;
                        dst_q    <= dst_i;
                        tcnt_q   <= '0;
                        state_q  <= S_ISSUE;
                        busy_q   <= 1'b1;
                        opcode_q <= OP_ADDI;
                        bus_oe_q <= 1'b1;
                        oe_n_q   <= 1'b0;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    // Writeback sits after the load above so it wins a same-register collision.
                    if (state_q == S_WAIT && cp_done_i && !done_q) begin
                        regs_q[dst_q] <= cp_bus_in_i;
                        cflag_q       <= cp_carry_i;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_IDLE;
                        busy_q        <= 1'b0;
                        opcode_q      <= '0;
                        bus_oe_q      <= 1'b0;
                        oe_n_q        <= 1'b1;
                    end else if (tcnt_q == TMO) begin
                        err_q    <= 1'b1;
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        opcode_q <= '0;
                        bus_oe_q <= 1'b0;
                        oe_n_q   <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 4'd1;
                        if (state_q == S_ISSUE && cp_bus_req_i == REQ_XFER) begin
                            state_q  <= S_WAIT;
                            bus_oe_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    opcode_q <= '0;
                    bus_oe_q <= 1'b0;
                    oe_n_q   <= 1'b1;
                end
            endcase
        end
    end

    assign rd_data_o    = regs_q[rd_addr_i];
    assign busy_o       = busy_q;
    assign res_valid_o  = res_valid_q;
    assign err_o        = err_q;
    assign cflag_o      = cflag_q;
    assign cp_opcode_o  = opcode_q;
    assign cp_imm_o     = imm_q;
    assign cp_bus_out_o = op_val_q;
    assign cp_bus_oe_o  = bus_oe_q;
    assign cp_oe_n_o    = oe_n_q;

endmodule

// File: tb/tb_addi_host_seq.sv
// Bench for addi_host_seq: behavioural coprocessor plus a register-file reference model,
// a table of directed ADDI vectors, hand sequences for corner cases and a randomized loop.
module tb_addi_host_seq;

    localparam int TMO      = 15;
    localparam int M_NORMAL = 0;
    localparam int M_NODONE = 1;
    localparam int M_STUCK  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, ld_en;
    logic [3:0] imm, ld_data;
    logic [1:0] src, dst, ld_addr, rd_addr;
    logic [3:0] rd_data;
    logic       busy, res_valid, err, cflag;
    logic [3:0] cp_opcode, cp_imm, cp_bus_out, cp_bus_req, cp_bus_in, m_drv;
    logic       cp_bus_oe, cp_oe_n, cp_done, cp_carry;

    assign cp_bus_in = cp_bus_oe ? cp_bus_out : m_drv;

    addi_host_seq #(.TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .imm_i(imm), .src_i(src), .dst_i(dst),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .busy_o(busy), .res_valid_o(res_valid), .err_o(err),
        .cflag_o(cflag), .cp_opcode_o(cp_opcode), .cp_imm_o(cp_imm),
        .cp_bus_req_i(cp_bus_req), .cp_bus_out_o(cp_bus_out), .cp_bus_oe_o(cp_bus_oe),
        .cp_bus_in_i(cp_bus_in), .cp_oe_n_o(cp_oe_n), .cp_done_i(cp_done), .cp_carry_i(cp_carry)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_regs [4];
    logic       exp_cflag;
    int         cp_mode;
    int         m_cnt;
    logic [3:0] m_operand;
    logic [4:0] m_res;

    // Coprocessor model: request codes after E1/E2, operand sampled at E3, done after E5.
    always @(posedge clk) begin
        logic [3:0] n_req;
        logic [3:0] n_drv;
        logic       n_done;
        logic       n_carry;
        n_req   = cp_bus_req;
        n_done  = cp_done;
        n_drv   = m_drv;
        n_carry = cp_carry;
        if (rst || cp_opcode != 4'd1) begin
            m_cnt   = 0;
            n_req   = 4'd0;
            n_done  = (cp_mode == M_STUCK) && !rst;
            n_drv   = 4'd0;
            n_carry = 1'b0;
        end else begin
            m_cnt++;
            if (m_cnt == 1) n_req = 4'b0011;
            else if (m_cnt == 2) n_req = 4'b0001;
            else if (m_cnt == 3) begin
                n_req     = 4'd0;
                m_operand = cp_bus_in;
                m_res     = {1'b0, cp_bus_in} + {1'b0, cp_imm};
            end else if (m_cnt == 5 && cp_mode == M_NORMAL) begin
                n_done  = 1'b1;
                n_drv   = m_res[3:0];
                n_carry = m_res[4];
            end
            if (cp_mode == M_STUCK) n_done = 1'b1;
        end
        #1;
        cp_bus_req = n_req;
        cp_done    = n_done;
        m_drv      = n_drv;
        cp_carry   = n_carry;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 32'(rd_data), 32'(exp_regs[i]));
        end
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        exp_regs[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // n counts negedges after the accept edge: n = k is the cycle following edge E0+k.
    task automatic run_op(input logic [3:0] i_imm, input logic [1:0] i_src, input logic [1:0] i_dst,
                          input int mode, input int ld_at, input logic [1:0] la, input logic [3:0] ldv,
                          input int start_at);
        int         sum;
        int         n;
        int         busy_n;
        bit         rv;
        bit         er;
        logic [3:0] opv;
        opv     = exp_regs[i_src];
        sum     = int'(opv) + int'(i_imm);
        cp_mode = mode;
        @(negedge clk);
        start = 1'b1; imm = i_imm; src = i_src; dst = i_dst;
        busy_n = 0; rv = 1'b0; er = 1'b0;
        for (n = 0; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            ld_en = 1'b0;
            if (res_valid) begin rv = 1'b1; break; end
            if (err) begin er = 1'b1; break; end
            if (busy) busy_n++;
            if (n == ld_at) begin
                ld_en = 1'b1; ld_addr = la; ld_data = ldv;
                exp_regs[la] = ldv;
            end
            if (n == start_at) begin
                start = 1'b1; imm = ~i_imm; src = ~i_src; dst = ~i_dst;
            end
        end
        start = 1'b0;
        ld_en = 1'b0;
        if (mode == M_NORMAL) begin
            chk("res_valid_seen", 32'(rv), 1);
            chk("latency", 32'(n), 6);
            chk("busy_cycles", 32'(busy_n), 6);
            chk("operand_sampled", 32'(m_operand), 32'(opv));
            exp_regs[i_dst] = 4'(sum);
            exp_cflag       = (sum > 15);
        end else begin
            chk("err_seen", 32'(er), 1);
            chk("timeout_latency", 32'(n), 32'(TMO + 1));
            chk("busy_cycles_tmo", 32'(busy_n), 32'(TMO + 1));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_quiet", 32'({res_valid, err, busy}), 0);
        end
        chk("cflag", 32'(cflag), 32'(exp_cflag));
        check_regs("op");
    endtask

    typedef struct {
        logic [3:0] src_val;
        logic [3:0] imm;
        logic [1:0] src;
        logic [1:0] dst;
        logic [3:0] exp_sum;
        logic       exp_c;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{4'h5, 4'h3, 2'd1, 2'd2, 4'h8, 1'b0};
        tbl[1] = '{4'h9, 4'h7, 2'd0, 2'd0, 4'h0, 1'b1};
        tbl[2] = '{4'hF, 4'h1, 2'd3, 2'd1, 4'h0, 1'b1};
        tbl[3] = '{4'h0, 4'h0, 2'd2, 2'd3, 4'h0, 1'b0};
        tbl[4] = '{4'h6, 4'h9, 2'd1, 2'd1, 4'hF, 1'b0};
        tbl[5] = '{4'hA, 4'hA, 2'd2, 2'd0, 4'h4, 1'b1};

        rst = 1'b1; start = 1'b0; ld_en = 1'b0; imm = '0; src = '0; dst = '0;
        ld_addr = '0; ld_data = '0; rd_addr = '0; cp_mode = M_NORMAL;
        for (int i = 0; i < 4; i++) exp_regs[i] = '0;
        exp_cflag = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cflag", 32'(cflag), 0);
        chk("rst_opcode", 32'(cp_opcode), 0);
        chk("rst_imm", 32'(cp_imm), 0);
        chk("rst_bus_oe", 32'(cp_bus_oe), 0);
        chk("rst_bus_out", 32'(cp_bus_out), 0);
        chk("rst_oe_n", 32'(cp_oe_n), 1);
        rst = 1'b0;
        check_regs("rst");

        for (int v = 0; v < 6; v++) begin
            load(tbl[v].src, tbl[v].src_val);
            run_op(tbl[v].imm, tbl[v].src, tbl[v].dst, M_NORMAL, -1, 2'd0, 4'd0, -1);
            rd_addr = tbl[v].dst;
            #1;
            chk($sformatf("tbl%0d_sum", v), 32'(rd_data), 32'(tbl[v].exp_sum));
            chk($sformatf("tbl%0d_carry", v), 32'(cflag), 32'(tbl[v].exp_c));
        end

        // coprocessor never finishes
        run_op(4'h2, 2'd1, 2'd3, M_NODONE, -1, 2'd0, 4'd0, -1);
        // stale done held high, then a normal op
        run_op(4'h4, 2'd2, 2'd1, M_STUCK, -1, 2'd0, 4'd0, -1);
        run_op(4'h3, 2'd1, 2'd2, M_NORMAL, -1, 2'd0, 4'd0, -1);
        // load collides with writeback on r3; spurious start while busy; load to src mid-op
        run_op(4'h4, 2'd1, 2'd3, M_NORMAL, 5, 2'd3, 4'hF, 2);
        run_op(4'h1, 2'd2, 2'd0, M_NORMAL, 1, 2'd2, 4'hC, -1);

        // reset sampled at E3 of an op
        load(2'd2, 4'h7);
        cp_mode = M_NORMAL;
        @(negedge clk);
        start = 1'b1; imm = 4'h5; src = 2'd2; dst = 2'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_opcode", 32'(cp_opcode), 0);
        chk("midrst_bus_oe", 32'(cp_bus_oe), 0);
        chk("midrst_cflag", 32'(cflag), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_regs[i] = '0;
        exp_cflag = 1'b0;
        check_regs("midrst");
        load(2'd0, 4'hB);
        run_op(4'h6, 2'd0, 2'd3, M_NORMAL, -1, 2'd0, 4'd0, -1);

        for (int it = 0; it < 25; it++) begin
            int r;
            int md;
            int l_at;
            int s_at;
            if ($urandom_range(0, 1) == 1) load(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            r    = int'($urandom_range(0, 9));
            md   = (r < 7) ? M_NORMAL : ((r < 9) ? M_NODONE : M_STUCK);
            l_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
            s_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1;
            run_op(4'($urandom), 2'($urandom), 2'($urandom), md, l_at, 2'($urandom), 4'($urandom), s_at);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
